// File: rtl/seg7_mmio_ctrl.sv
// ---------------------------------------------------------------------------
// seg7_mmio_ctrl
//
// Memory-mapped slave between the CPU bus decoder and the 8-digit
// seven-segment display driver. The CPU writes a display value (DATA) and a
// mode bit (CTRL). In hex mode the value is forwarded to the display as-is.
// In decimal mode it is converted to 8 packed BCD digits by a sequential
// shift-add-3 engine, one bit per cycle.
//
// Register map (word offsets):
//   0 DATA   rw  last accepted display value
//   1 CTRL   rw  bit0 mode (0 = hex, 1 = decimal), other bits read 0
//   2 STATUS ro  bit0 busy, bit1 drop (sticky, write 1 to clear), bit2 ovf
//   3 reserved, reads 0, writes ignored
//
// Ports:
//   clk, reset       system clock, synchronous active-high reset
//   i_cs, i_we       bus select / write enable
//   i_addr, i_wdata  word offset and write data
//   o_rdata          combinational read data (0 when not selected)
//   o_busy           high whenever the FSM is not IDLE (including DONE)
//   o_seg_cs         one-cycle load strobe to the display driver
//   o_seg_data       display word, digit 0 in bits [3:0]
//   o_dbg_state      current FSM state, for observation only
//
// Handshake: the bus side has no ready. A write is a single-cycle event
// (i_cs && i_we at a clk edge) and is always completed that cycle; a DATA
// write that arrives while busy is discarded and recorded in the drop flag.
// The display side is a push: o_seg_cs high for one cycle qualifies
// o_seg_data, and the driver is assumed to always accept it.
// ---------------------------------------------------------------------------
module seg7_mmio_ctrl #(
  parameter int          CONV_BITS   = 32,
  parameter logic [31:0] DEC_MAX     = 32'd99_999_999,
  parameter logic [31:0] OVF_PATTERN = 32'hEEEE_EEEE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_cs,
  input  logic        i_we,
  input  logic [1:0]  i_addr,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_busy,
  output logic        o_seg_cs,
  output logic [31:0] o_seg_data,
  output logic [1:0]  o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CHECK   = 2'd1,
    S_CONVERT = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam int CW = (CONV_BITS > 1) ? $clog2(CONV_BITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CONV_BITS - 1);

  state_t                 state_q;
  logic [31:0]            data_q;
  logic                   mode_q;
  logic                   drop_q;
  logic                   ovf_q;
  logic [CW-1:0]          cnt_q;
  logic [CONV_BITS-1:0]   bin_q;
  logic [31:0]            bcd_q;
  logic                   seg_cs_q;
  logic [31:0]            seg_data_q;

  logic [CONV_BITS-1:0]   bin_d;
  logic [31:0]            bcd_d;
  logic [31:0]            bcd_adj;

  logic wr_data;
  logic wr_ctrl;
  logic wr_status;
  logic busy;

  assign wr_data   = i_cs && i_we && (i_addr == 2'd0);
  assign wr_ctrl   = i_cs && i_we && (i_addr == 2'd1);
  assign wr_status = i_cs && i_we && (i_addr == 2'd2);
  assign busy      = (state_q != S_IDLE);

  // One shift-add-3 step: correct every digit that would reach 10 or more
  // after doubling, then shift the binary MSB into the BCD LSB.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 8; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
    {bcd_d, bin_d} = {bcd_adj[30:0], bin_q, 1'b0};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      data_q     <= '0;
      mode_q     <= 1'b0;
      drop_q     <= 1'b0;
      ovf_q      <= 1'b0;
      cnt_q      <= '0;
      bin_q      <= '0;
      bcd_q      <= '0;
      seg_cs_q   <= 1'b0;
      seg_data_q <= '0;
    end else begin
      // Mode may change at any time; it is only sampled when a DATA write
      // is accepted, so an in-flight conversion is unaffected.
      if (wr_ctrl) begin
        mode_q <= i_wdata[0];
      end

      // A drop event in the same cycle as a clear wins: the flag stays set.
      if (wr_data && busy) begin
        drop_q <= 1'b1;
      end else if (wr_status && i_wdata[1]) begin
        drop_q <= 1'b0;
      end

      seg_cs_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (wr_data) begin
            data_q <= i_wdata;
            if (mode_q) begin
              state_q <= S_CHECK;
            end else begin
              seg_data_q <= i_wdata;
              seg_cs_q   <= 1'b1;
              state_q    <= S_DONE;
            end
          end
        end

        S_CHECK: begin
          if (data_q > DEC_MAX) begin
            ovf_q      <= 1'b1;
            seg_data_q <= OVF_PATTERN;
            seg_cs_q   <= 1'b1;
            state_q    <= S_DONE;
          end else begin
            ovf_q   <= 1'b0;
            bin_q   <= data_q[CONV_BITS-1:0];
            bcd_q   <= '0;
            cnt_q   <= '0;
            state_q <= S_CONVERT;
          end
        end

        S_CONVERT: begin
          bin_q <= bin_d;
          bcd_q <= bcd_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            seg_data_q <= bcd_d;
            seg_cs_q   <= 1'b1;
            state_q    <= S_DONE;
          end
        end

        S_DONE: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    o_rdata = '0;
    if (i_cs) begin
      case (i_addr)
        2'd0:    o_rdata = data_q;
        2'd1:    o_rdata = {31'b0, mode_q};
        2'd2:    o_rdata = {29'b0, ovf_q, drop_q, busy};
        default: o_rdata = '0;
      endcase
    end
  end

  assign o_busy      = busy;
  assign o_seg_cs    = seg_cs_q;
  assign o_seg_data  = seg_data_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_seg7_mmio_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seg7_mmio_ctrl
//
// Directed self-checking bench for seg7_mmio_ctrl. Cycle numbering: a write
// sampled at clock edge T; "at T+k" means the value the outputs hold just
// before edge T+k, sampled on the falling edge in between.
// ---------------------------------------------------------------------------
module tb_seg7_mmio_ctrl;

  localparam logic [1:0] A_DATA = 2'd0;
  localparam logic [1:0] A_CTRL = 2'd1;
  localparam logic [1:0] A_STAT = 2'd2;
  localparam logic [1:0] A_RSVD = 2'd3;

  logic        clk;
  logic        reset;
  logic        i_cs;
  logic        i_we;
  logic [1:0]  i_addr;
  logic [31:0] i_wdata;
  logic [31:0] o_rdata;
  logic        o_busy;
  logic        o_seg_cs;
  logic [31:0] o_seg_data;
  logic [1:0]  o_dbg_state;

  int checks   = 0;
  int failures = 0;

  seg7_mmio_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .i_cs        (i_cs),
    .i_we        (i_we),
    .i_addr      (i_addr),
    .i_wdata     (i_wdata),
    .o_rdata     (o_rdata),
    .o_busy      (o_busy),
    .o_seg_cs    (o_seg_cs),
    .o_seg_data  (o_seg_data),
    .o_dbg_state (o_dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  // Write occupies exactly one clock edge; returns 1 time unit after it.
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    i_cs = 1'b1; i_we = 1'b1; i_addr = a; i_wdata = d;
    @(posedge clk);
    #1;
    i_cs = 1'b0; i_we = 1'b0; i_wdata = '0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    i_cs = 1'b1; i_we = 1'b0; i_addr = a;
    #1;
    d = o_rdata;
    i_cs = 1'b0;
  endtask

  // Watches n cycles after a write and summarises strobe/busy activity.
  task automatic observe(input int n, output int n_strobe, output int first_strobe,
                         output logic [31:0] strobe_data, output int n_busy,
                         output int last_busy);
    n_strobe = 0; first_strobe = -1; strobe_data = '0; n_busy = 0; last_busy = -1;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if (o_seg_cs) begin
        n_strobe++;
        if (first_strobe < 0) first_strobe = k;
        strobe_data = o_seg_data;
      end
      if (o_busy) begin
        n_busy++;
        last_busy = k;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] rd;
    reset = 1'b1; i_cs = 1'b0; i_we = 1'b0; i_addr = '0; i_wdata = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++; if (o_seg_cs !== 1'b0) begin failures++; $display("FAIL reset_seg_cs: got %b expected 0", o_seg_cs); end
    checks++; if (o_seg_data !== 32'h0) begin failures++; $display("FAIL reset_seg_data: got %h expected 00000000", o_seg_data); end
    checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", o_busy); end
    bus_read(A_DATA, rd);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL reset_data_reg: got %h expected 00000000", rd); end
    bus_read(A_STAT, rd);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL reset_status: got %h expected 00000000", rd); end
  endtask

  task automatic test_hex();
    int ns, fs, nb, lb;
    logic [31:0] sd;
    bus_write(A_DATA, 32'h1234_ABCD);
    observe(5, ns, fs, sd, nb, lb);
    checks++; if (ns !== 1 || fs !== 1) begin failures++; $display("FAIL hex_strobe: got count=%0d at=%0d expected count=1 at=1", ns, fs); end
    checks++; if (sd !== 32'h1234_ABCD) begin failures++; $display("FAIL hex_data: got %h expected 1234abcd", sd); end
    checks++; if (nb !== 1 || lb !== 1) begin failures++; $display("FAIL hex_busy: got count=%0d last=%0d expected count=1 last=1", nb, lb); end
    checks++; if (o_seg_data !== 32'h1234_ABCD) begin failures++; $display("FAIL hex_hold: got %h expected 1234abcd", o_seg_data); end
  endtask

  task automatic test_decimal_value(input logic [31:0] val, input logic [31:0] exp_word,
                                    input int exp_lat, input logic [31:0] exp_status);
    int ns, fs, nb, lb;
    logic [31:0] sd, rd;
    bus_write(A_DATA, val);
    observe(40, ns, fs, sd, nb, lb);
    checks++; if (ns !== 1 || fs !== exp_lat) begin failures++; $display("FAIL dec_strobe(%0d): got count=%0d at=%0d expected count=1 at=%0d", val, ns, fs, exp_lat); end
    checks++; if (sd !== exp_word) begin failures++; $display("FAIL dec_data(%0d): got %h expected %h", val, sd, exp_word); end
    checks++; if (nb !== exp_lat || lb !== exp_lat) begin failures++; $display("FAIL dec_busy(%0d): got count=%0d last=%0d expected %0d", val, nb, lb, exp_lat); end
    bus_read(A_STAT, rd);
    checks++; if (rd !== exp_status) begin failures++; $display("FAIL dec_status(%0d): got %h expected %h", val, rd, exp_status); end
  endtask

  task automatic test_decimal();
    logic [31:0] rd;
    bus_write(A_CTRL, 32'hFFFF_FFFF);
    bus_read(A_CTRL, rd);
    checks++; if (rd !== 32'h1) begin failures++; $display("FAIL ctrl_read: got %h expected 00000001", rd); end
    test_decimal_value(32'd12_345_678, 32'h1234_5678, 34, 32'h0);
    test_decimal_value(32'd0,          32'h0000_0000, 34, 32'h0);
    test_decimal_value(32'd99_999_999, 32'h9999_9999, 34, 32'h0);
    test_decimal_value(32'd100_000_000, 32'hEEEE_EEEE, 2, 32'h4);
    test_decimal_value(32'd4_096,      32'h0000_4096, 34, 32'h0);
  endtask

  task automatic test_drop();
    int ns, fs;
    logic [31:0] sd, rd;
    ns = 0; fs = -1; sd = '0;
    bus_write(A_CTRL, 32'h1);
    bus_write(A_DATA, 32'h0000_0255);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (o_seg_cs) begin
        ns++;
        if (fs < 0) fs = k;
        sd = o_seg_data;
      end
      if (k == 10) bus_write(A_DATA, 32'h5);
    end
    checks++; if (ns !== 1 || fs !== 34) begin failures++; $display("FAIL drop_strobe: got count=%0d at=%0d expected count=1 at=34", ns, fs); end
    checks++; if (sd !== 32'h0000_0597) begin failures++; $display("FAIL drop_result: got %h expected 00000597", sd); end
    bus_read(A_DATA, rd);
    checks++; if (rd !== 32'h0000_0255) begin failures++; $display("FAIL drop_data_reg: got %h expected 00000255", rd); end
    bus_read(A_STAT, rd);
    checks++; if (rd !== 32'h2) begin failures++; $display("FAIL drop_flag: got %h expected 00000002", rd); end
    // Writes to reserved offset and to STATUS bits other than bit1 change nothing.
    bus_write(A_RSVD, 32'hFFFF_FFFF);
    bus_write(A_STAT, 32'hFFFF_FFFD);
    bus_read(A_STAT, rd);
    checks++; if (rd !== 32'h2) begin failures++; $display("FAIL status_ignored_bits: got %h expected 00000002", rd); end
    bus_read(A_RSVD, rd);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL rsvd_read: got %h expected 00000000", rd); end
    bus_write(A_STAT, 32'h2);
    bus_read(A_STAT, rd);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL drop_clear: got %h expected 00000000", rd); end
    // Reads return 0 whenever the device is not selected.
    i_cs = 1'b0; i_addr = A_DATA; #1;
    checks++; if (o_rdata !== 32'h0) begin failures++; $display("FAIL rdata_unselected: got %h expected 00000000", o_rdata); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    bus_write(A_CTRL, 32'h0);
    bus_write(A_DATA, 32'hAAAA_0001);
    // This edge lands on the DONE cycle of the first write.
    bus_write(A_DATA, 32'hBBBB_0002);
    checks++; if (o_seg_cs !== 1'b0 || o_busy !== 1'b0) begin failures++; $display("FAIL b2b_dropped: got cs=%b busy=%b expected 0 0", o_seg_cs, o_busy); end
    checks++; if (o_seg_data !== 32'hAAAA_0001) begin failures++; $display("FAIL b2b_hold: got %h expected aaaa0001", o_seg_data); end
    // First IDLE cycle after DONE: accepted.
    bus_write(A_DATA, 32'hBBBB_0002);
    checks++; if (o_seg_cs !== 1'b1 || o_seg_data !== 32'hBBBB_0002) begin failures++; $display("FAIL b2b_accept: got cs=%b data=%h expected 1 bbbb0002", o_seg_cs, o_seg_data); end
    bus_read(A_STAT, rd);
    checks++; if (rd[1] !== 1'b1) begin failures++; $display("FAIL b2b_drop_flag: got %b expected 1", rd[1]); end
    @(negedge clk);
    bus_write(A_STAT, 32'h2);
  endtask

  task automatic test_reset_mid_conversion();
    int ns, fs, nb, lb;
    logic [31:0] sd, rd;
    bus_write(A_CTRL, 32'h1);
    bus_write(A_DATA, 32'd87_654_321);
    repeat (15) @(negedge clk);
    checks++; if (o_busy !== 1'b1 || o_seg_data !== 32'hBBBB_0002) begin failures++; $display("FAIL midreset_pre: got busy=%b data=%h expected 1 bbbb0002", o_busy, o_seg_data); end
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++; if (o_busy !== 1'b0 || o_seg_cs !== 1'b0) begin failures++; $display("FAIL midreset_busy: got busy=%b cs=%b expected 0 0", o_busy, o_seg_cs); end
    checks++; if (o_seg_data !== 32'h0) begin failures++; $display("FAIL midreset_seg_data: got %h expected 00000000", o_seg_data); end
    bus_read(A_CTRL, rd);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL midreset_ctrl: got %h expected 00000000", rd); end
    observe(40, ns, fs, sd, nb, lb);
    checks++; if (ns !== 0 || nb !== 0) begin failures++; $display("FAIL midreset_quiet: got strobes=%0d busy=%0d expected 0 0", ns, nb); end
    bus_write(A_DATA, 32'hCAFE_0001);
    observe(5, ns, fs, sd, nb, lb);
    checks++; if (ns !== 1 || fs !== 1 || sd !== 32'hCAFE_0001) begin failures++; $display("FAIL midreset_hex: got count=%0d at=%0d data=%h expected 1 1 cafe0001", ns, fs, sd); end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_hex();
    test_decimal();
    test_drop();
    test_back_to_back();
    test_reset_mid_conversion();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net: the directed sequence is a few hundred cycles.
  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected finish before 200000");
    $fatal(1);
  end

endmodule

// File: doc/seg7_mmio_ctrl.md
Name: seg7_mmio_ctrl

Overview:
- Memory-mapped I/O slave between the CPU data-bus decoder and the 8-digit seven-segment display driver.
- Accepts CPU word writes of a display value and a mode register.
- Hex mode: forwards the value unchanged. Decimal mode: converts the unsigned binary value to 8 packed BCD digits with a sequential shift-add-3 engine.
- Drives the display driver's chip-select strobe and 32-bit data.

Parameters:
- CONV_BITS, 32, width of the binary value fed to the converter. Equals the shift-cycle count.
- DEC_MAX, 32'd99_999_999, largest value representable in 8 BCD digits.
- OVF_PATTERN, 32'hEEEE_EEEE, display word emitted on decimal overflow.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- i_cs  in  1  device select from the bus address decoder
- i_we  in  1  write enable; a write occurs when i_cs && i_we at a clk edge
- i_addr  in  2  word offset: 0 = DATA, 1 = CTRL, 2 = STATUS, 3 = reserved
- i_wdata  in  32  write data
- o_rdata  out  32  read data (combinational)
- o_busy  out  1  conversion in progress
- o_seg_cs  out  1  one-cycle load strobe to the display driver
- o_seg_data  out  32  display word (8 nibbles, digit 0 = [3:0])

Behaviour:
- Reset (clk edge with reset=1) forces every register to zero:
  - state=IDLE, data_reg=0, mode=0, sticky flags=0, bit counter=0
  - o_seg_cs=0, o_seg_data=0, o_busy=0
  - Applies mid-conversion: the conversion is abandoned and no strobe is emitted.
- Registers:
  - DATA (rw): last accepted value.
  - CTRL (rw): bit0 mode (0 hex, 1 decimal); other bits read 0. A CTRL write is always accepted, including while busy; it affects only later DATA writes.
  - STATUS (ro): bit0 busy, bit1 drop (sticky), bit2 ovf (last decimal conversion overflowed).
    - Writing STATUS with bit1=1 clears drop.
    - If a drop event and a clear happen on the same cycle, drop remains set.
- o_rdata:
  - offset 0 → data_reg, 1 → {31'b0, mode}, 2 → status, 3 → 0.
  - 0 whenever i_cs=0.
- FSM states: IDLE, CHECK, CONVERT, DONE.
  - IDLE, DATA write: latch data_reg=i_wdata and sample mode.
    - mode=0 → DONE with result=i_wdata.
    - mode=1 → CHECK.
  - CHECK (1 cycle):
    - data_reg > DEC_MAX → result=OVF_PATTERN, ovf=1, go to DONE.
    - Otherwise → ovf=0, load shift reg=data_reg, bcd=0, counter=0, go to CONVERT.
  - CONVERT (exactly CONV_BITS cycles), each cycle:
    - add 3 to every BCD nibble ≥5;
    - shift {bcd, bin} left by 1;
    - counter+1.
    - After the cycle with counter=CONV_BITS-1, go to DONE with result=bcd.
  - DONE (1 cycle): o_seg_cs=1, o_seg_data=result, then go to IDLE.
- Outputs are registered:
  - o_seg_cs is high iff state==DONE.
  - o_seg_data updates only on entry to DONE and holds its value otherwise.
- Latency, from the DATA write edge T:
  - hex: strobe at T+1
  - decimal: strobe at T+34
  - decimal overflow: strobe at T+2
- o_busy = (state != IDLE); it is high during DONE.
- A DATA write while busy is dropped: data_reg and the conversion are unaffected, drop is set.
- Back-to-back DATA writes: a write on the DONE cycle is dropped. A write on the first IDLE cycle after DONE is accepted.
- Writes to offset 3 and STATUS bits other than bit1 are ignored.
- Value 0 in decimal mode gives 0x00000000. DEC_MAX gives 0x99999999.

Test Plan:
- Reset, then mode=0, write DATA=0x1234ABCD at edge T → o_seg_cs=1 only at T+1, o_seg_data=0x1234ABCD, o_busy high only for cycle T+1.
- CTRL=1, write DATA=32'd12345678 → o_busy high T+1..T+34, o_seg_cs at T+34 with 0x12345678, STATUS=0b000 afterwards.
- Decimal writes of 0 and 99_999_999 → 0x00000000 and 0x99999999 each at T+34. Write 100_000_000 → 0xEEEEEEEE at T+2, STATUS bit2=1.
- Decimal write 0x00000255, then DATA=0x5 at T+10 → single strobe with 0x00000597, data_reg reads 0x255, STATUS bit1=1. Write STATUS=0x2 → bit1 reads 0.
- Assert reset at T+15 of a decimal conversion → no strobe, o_seg_data=0, o_busy=0, CTRL reads 0. A new hex write works normally.
- Hex write on the DONE cycle of a previous hex write is dropped. The same write one cycle later strobes with the new value.
